// File: rtl/wave_capture_multi.sv
// wave_capture_multi: triggered, decimated capture of one sample channel into a double-buffered display RAM.
module wave_capture_multi #(
    parameter int SAMPLE_W   = 16,
    parameter int OUT_W      = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int CHANNELS   = 2,
    parameter int CSW        = (CHANNELS > 1 ? $clog2(CHANNELS) : 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         new_sample_ready,
    input  logic [CHANNELS*SAMPLE_W-1:0] new_sample_in,
    input  logic [CSW-1:0]               chan_sel,
    input  logic [1:0]                   trig_mode,
    input  logic signed [SAMPLE_W-1:0]   trig_level,
    input  logic [3:0]                   decim,
    input  logic                         wave_display_idle,
    output logic [DEPTH_LOG2:0]          write_address,
    output logic                         write_enable,
    output logic [OUT_W-1:0]             write_sample,
    output logic                         read_index,
    output logic                         capture_done
);
    typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;
    localparam logic [OUT_W-1:0] MSB_MASK = OUT_W'(1) << (OUT_W - 1);

    state_t                       state, state_n;
    logic [DEPTH_LOG2-1:0]        index, index_n;
    logic [3:0]                   dcnt, dcnt_n, decim_r, decim_n;
    logic                         read_index_n, prev_valid, prev_valid_n;
    logic signed [SAMPLE_W-1:0]   prev, prev_n, level_r, level_n, cur;
    logic [CSW-1:0]               sel_r, sel_n;
    logic [1:0]                   mode_r, mode_n;
    logic                         we_n, done_n, rise, fall, trig;
    logic [OUT_W-1:0]             sample_n;
    logic [DEPTH_LOG2:0]          address_n;

    assign cur  = new_sample_in[sel_r*SAMPLE_W +: SAMPLE_W];
    assign rise = prev < level_r && cur >= level_r;
    assign fall = prev >= level_r && cur < level_r;
    // Free-run fires on any sample; edge modes need a valid previous sample.
    assign trig = new_sample_ready && (mode_r == 2'b10 || prev_valid &&
                  (mode_r == 2'b00 ? rise : mode_r == 2'b01 ? fall : rise || fall));

    always_comb begin
        state_n      = state;
        index_n      = index;
        dcnt_n       = dcnt;
        read_index_n = read_index;
        prev_n       = prev;
        prev_valid_n = prev_valid;
        sel_n        = sel_r;
        mode_n       = mode_r;
        level_n      = level_r;
        decim_n      = decim_r;
        we_n         = 1'b0;
        done_n       = 1'b0;
        case (state)
            ARMED: begin
                sel_n   = chan_sel;
                mode_n  = trig_mode;
                level_n = trig_level;
                decim_n = decim;
                if (new_sample_ready) begin
                    prev_n       = cur;
                    prev_valid_n = 1'b1;
                end
                if (chan_sel != sel_r || trig)
                    prev_valid_n = 1'b0;
                if (trig) begin
                    state_n = ACTIVE;
                    we_n    = 1'b1;
                    index_n = index + 1'b1;
                    dcnt_n  = 4'd0;
                end
            end
            ACTIVE: begin
                if (new_sample_ready && dcnt == decim_r) begin
                    we_n    = 1'b1;
                    index_n = index + 1'b1;
                    dcnt_n  = 4'd0;
                    done_n  = &index;
                    state_n = &index ? WAIT : ACTIVE;
                end else if (new_sample_ready)
                    dcnt_n = dcnt + 4'd1;
            end
            WAIT: begin
                if (wave_display_idle) begin
                    read_index_n = ~read_index;
                    prev_valid_n = 1'b0;
                    state_n      = ARMED;
                end
            end
            default: state_n = ARMED;
        endcase
        sample_n  = we_n ? cur[SAMPLE_W-1 -: OUT_W] ^ MSB_MASK : write_sample;
        address_n = we_n ? {~read_index, index} : {~read_index_n, index_n};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ARMED;
            index         <= '0;
            dcnt          <= '0;
            read_index    <= 1'b0;
            prev          <= '0;
            prev_valid    <= 1'b0;
            sel_r         <= '0;
            mode_r        <= '0;
            level_r       <= '0;
            decim_r       <= '0;
            write_enable  <= 1'b0;
            capture_done  <= 1'b0;
            write_sample  <= '0;
            write_address <= {1'b1, {DEPTH_LOG2{1'b0}}};
        end else begin
            state         <= state_n;
            index         <= index_n;
            dcnt          <= dcnt_n;
            read_index    <= read_index_n;
            prev          <= prev_n;
            prev_valid    <= prev_valid_n;
            sel_r         <= sel_n;
            mode_r        <= mode_n;
            level_r       <= level_n;
            decim_r       <= decim_n;
            write_enable  <= we_n;
            capture_done  <= done_n;
            write_sample  <= sample_n;
            write_address <= address_n;
        end
    end
endmodule

// File: tb/tb_wave_capture_multi.sv
// tb_wave_capture_multi: scoreboard bench for wave_capture_multi at default parameters.
module tb_wave_capture_multi;
    logic        clk, reset, new_sample_ready, wave_display_idle;
    logic [31:0] new_sample_in;
    logic        chan_sel;
    logic [1:0]  trig_mode;
    logic [15:0] trig_level;
    logic [3:0]  decim;
    logic [8:0]  write_address;
    logic        write_enable, read_index, capture_done;
    logic [7:0]  write_sample;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] smp;
        logic       done;
    } exp_t;
    exp_t exp_q[$];
    int tests = 0, fails = 0;

    wave_capture_multi dut (
        .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
        .new_sample_in(new_sample_in), .chan_sel(chan_sel), .trig_mode(trig_mode),
        .trig_level(trig_level), .decim(decim), .wave_display_idle(wave_display_idle),
        .write_address(write_address), .write_enable(write_enable),
        .write_sample(write_sample), .read_index(read_index), .capture_done(capture_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic push(input logic [8:0] a, input logic [15:0] v, input logic d);
        exp_q.push_back('{a, {~v[15], v[14:8]}, d});
    endtask

    task automatic send(input logic [15:0] c0, input logic [15:0] c1);
        new_sample_in    = {c1, c0};
        new_sample_ready = 1'b1;
        @(posedge clk);
        #1 new_sample_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_idle();
        wave_display_idle = 1'b1;
        @(posedge clk);
        #1 wave_display_idle = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (write_enable) begin
                if (exp_q.size() == 0)
                    check("unexpected_write", write_enable, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("write_address", write_address, e.addr);
                    check("write_sample", write_sample, e.smp);
                    check("capture_done", capture_done, e.done);
                end
            end else
                check("done_without_write", capture_done, 0);
        end
    end

    initial begin
        logic [15:0] v;
        reset = 0; new_sample_ready = 0; new_sample_in = 0; wave_display_idle = 0;
        chan_sel = 0; trig_mode = 2'b00; trig_level = 16'h0000; decim = 0;
        idle_cycles(3);
        check("rst_address", write_address, 9'h100);
        check("rst_we", write_enable, 0);
        check("rst_sample", write_sample, 0);
        check("rst_read_index", read_index, 0);
        check("rst_done", capture_done, 0);
        @(negedge clk) reset = 1;
        idle_cycles(3);

        // rising through 0 on ch0, full capture into upper half
        send(16'hF23C, 16'h0);
        push(9'h100, 16'h0245, 0);
        send(16'h0245, 16'h0);
        for (int i = 1; i < 256; i++) begin
            push(9'(9'h100 + i), 16'h0245, i == 255);
            send(16'h0245, 16'h0);
        end
        idle_cycles(1);
        check("cap1_drained", exp_q.size(), 0);
        check("wait_address", write_address, 9'h100);
        for (int i = 0; i < 5; i++) send(16'h0245, 16'h0);
        idle_cycles(20);
        check("wait_read_index", read_index, 0);
        pulse_idle();
        check("swap_read_index", read_index, 1);
        check("swap_address", write_address, 9'h000);

        // second capture into lower half, aborted by reset at index 37
        idle_cycles(2);
        send(16'hF000, 16'h0);
        for (int i = 0; i < 37; i++) begin
            push(9'(i), 16'h1234, 0);
            send(16'h1234, 16'h0);
        end
        idle_cycles(1);
        check("cap2_drained", exp_q.size(), 0);
        check("cap2_address", write_address, 9'h025);
        reset = 0;
        #1;
        check("mid_rst_address", write_address, 9'h100);
        check("mid_rst_read_index", read_index, 0);
        check("mid_rst_we", write_enable, 0);
        @(negedge clk) reset = 1;
        idle_cycles(2);
        send(16'h1234, 16'h0);
        send(16'h1234, 16'h0);
        idle_cycles(1);
        check("no_rearm_address", write_address, 9'h100);

        // falling through 0x1000 on ch1 while ch0 toggles
        chan_sel = 1; trig_mode = 2'b01; trig_level = 16'h1000;
        idle_cycles(3);
        send(16'h7FFF, 16'h2000);
        send(16'h8000, 16'h2000);
        send(16'h7FFF, 16'h2000);
        push(9'h100, 16'h0FFF, 0);
        send(16'h8000, 16'h0FFF);
        for (int i = 1; i < 256; i++) begin
            push(9'(9'h100 + i), 16'h0FFF, i == 255);
            send(16'h7FFF ^ 16'(i), 16'h0FFF);
        end
        idle_cycles(1);
        check("cap3_drained", exp_q.size(), 0);
        pulse_idle();
        check("swap2_read_index", read_index, 1);

        // free-run with decim 3: one write per 4 samples
        chan_sel = 0; trig_mode = 2'b10; decim = 4'd3;
        idle_cycles(3);
        for (int k = 1; k <= 4 * 255 + 1; k++) begin
            v = 16'(k * 37 + 16'h0100);
            if ((k - 1) % 4 == 0)
                push(9'((k - 1) / 4), v, k == 4 * 255 + 1);
            send(v, 16'h0);
        end
        for (int i = 0; i < 3; i++) send(16'h4000, 16'h0);
        idle_cycles(2);
        check("cap4_drained", exp_q.size(), 0);
        check("final_read_index", read_index, 1);
        check("final_address", write_address, 9'h000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
